// File: rtl/esn7e_demo_avalon_st_adapter_latency_adapter_0.sv
// -----------------------------------------------------------------------------
// esn7e_demo_avalon_st_adapter_latency_adapter_0
//
// Purpose:
//   Avalon-ST timing adapter. The upstream source has a ready latency of
//   READY_LATENCY: it may only present a beat READY_LATENCY cycles after it
//   saw in_ready high. The downstream sink uses plain valid/ready (latency 0)
//   and may stall at any time. Beats that are already in flight when the
//   sink stalls are caught in a small FIFO, so nothing is lost.
//
// Ports:
//   clk        rising-edge clock for all logic
//   reset      synchronous, active-high; flushes FIFO and grant history
//   in_valid   upstream beat valid (arrives READY_LATENCY cycles after grant)
//   in_data    upstream payload
//   in_ready   grant to upstream; a beat may arrive READY_LATENCY cycles later
//   out_valid  downstream beat valid
//   out_data   downstream payload (head of FIFO, no extra latency)
//   out_ready  downstream ready
//   proto_err  sticky flag: a beat arrived in a cycle that had no grant
// -----------------------------------------------------------------------------
module esn7e_demo_avalon_st_adapter_latency_adapter_0 #(
    parameter int DATA_WIDTH    = 32,
    parameter int READY_LATENCY = 1,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  proto_err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = $clog2(FIFO_DEPTH + READY_LATENCY + 1);

    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic [READY_LATENCY-1:0] hist_q, hist_d;
    logic                     proto_err_q, proto_err_d;
    logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];

    logic [SW-1:0]            credit_used;
    logic                     grant_now;
    logic                     wr_en;
    logic                     pop_en;

    // Every stored beat plus every grant still in flight must fit in the
    // FIFO. Pops in the current cycle are deliberately not credited, which
    // keeps the grant decision purely registered and overflow impossible.
    always_comb begin
        credit_used = SW'(count_q);
        for (int i = 0; i < READY_LATENCY; i++) begin
            credit_used = credit_used + SW'(hist_q[i]);
        end
    end

    assign in_ready  = !reset && (credit_used < SW'(FIFO_DEPTH));
    assign out_valid = !reset && (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign proto_err = proto_err_q;

    // Oldest bit of the history is the grant issued READY_LATENCY cycles ago.
    assign grant_now = hist_q[READY_LATENCY-1];
    assign wr_en     = !reset && in_valid && grant_now;
    assign pop_en    = out_valid && out_ready;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        hist_d      = hist_q;
        proto_err_d = proto_err_q;

        hist_d = (hist_q << 1) | READY_LATENCY'(in_ready);

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(wr_en) - CW'(pop_en);

        // Ungranted beats are dropped, never written.
        if (in_valid && !grant_now) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            hist_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            hist_q      <= hist_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_esn7e_demo_avalon_st_adapter_latency_adapter_0.sv
module tb_esn7e_demo_avalon_st_adapter_latency_adapter_0;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance 0: READY_LATENCY=1, instance 1: READY_LATENCY=3
    logic        reset0, in_valid0, in_ready0, out_valid0, out_ready0, proto_err0;
    logic [31:0] in_data0, out_data0;
    logic        reset1, in_valid1, in_ready1, out_valid1, out_ready1, proto_err1;
    logic [31:0] in_data1, out_data1;

    esn7e_demo_avalon_st_adapter_latency_adapter_0 #(
        .DATA_WIDTH(32), .READY_LATENCY(1), .FIFO_DEPTH(DEPTH)
    ) u_rl1 (
        .clk(clk), .reset(reset0), .in_valid(in_valid0), .in_data(in_data0),
        .in_ready(in_ready0), .out_valid(out_valid0), .out_data(out_data0),
        .out_ready(out_ready0), .proto_err(proto_err0)
    );

    esn7e_demo_avalon_st_adapter_latency_adapter_0 #(
        .DATA_WIDTH(32), .READY_LATENCY(3), .FIFO_DEPTH(DEPTH)
    ) u_rl3 (
        .clk(clk), .reset(reset1), .in_valid(in_valid1), .in_data(in_data1),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
        .out_ready(out_ready1), .proto_err(proto_err1)
    );

    int          tests = 0;
    int          fails = 0;

    // Reference model: grants as arrival-cycle numbers, stored beats as a queue.
    int          cur = 0;
    int          rl = 1;
    int          cyc = 0;
    int          grants[$];
    logic [31:0] sb[$];
    bit          model_err = 1'b0;
    logic [31:0] next_data = '0;
    int          pops = 0;
    int          first_pop = -1;
    int          last_pop = -1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit r, input bit v, input logic [31:0] d, input bit o);
        if (cur == 0) begin
            reset0 = r; in_valid0 = v; in_data0 = d; out_ready0 = o;
        end else begin
            reset1 = r; in_valid1 = v; in_data1 = d; out_ready1 = o;
        end
    endtask

    task automatic sample(output logic ir, output logic ov, output logic pe, output logic [31:0] od);
        if (cur == 0) begin
            ir = in_ready0; ov = out_valid0; pe = proto_err0; od = out_data0;
        end else begin
            ir = in_ready1; ov = out_valid1; pe = proto_err1; od = out_data1;
        end
    endtask

    // One clock cycle on the selected instance. Upstream sends only on a
    // granted slot (when send=1); bad=1 injects 0xDEAD on an ungranted slot.
    task automatic step(input bit rst, input bit send, input bit bad, input bit ordy);
        bit          due;
        bit          sending;
        bit          badnow;
        bit          exp_rdy;
        logic [31:0] d;
        logic        ir, ov, pe;
        logic [31:0] od;
        due     = (grants.size() != 0) && (grants[0] == cyc);
        sending = !rst && due && send;
        badnow  = !rst && bad && !due;
        d       = sending ? next_data : (badnow ? 32'hDEAD : $urandom());
        drive(rst, sending || badnow, d, ordy);
        #1;
        sample(ir, ov, pe, od);
        if (rst) begin
            check("rst_in_ready", {31'b0, ir}, 32'd0);
            check("rst_out_valid", {31'b0, ov}, 32'd0);
        end else begin
            exp_rdy = (sb.size() + grants.size()) < DEPTH;
            check("in_ready", {31'b0, ir}, {31'b0, exp_rdy});
            check("out_valid", {31'b0, ov}, {31'b0, sb.size() != 0});
            if (ov === 1'b1 && ordy && sb.size() != 0) begin
                check("out_data", od, sb[0]);
                void'(sb.pop_front());
                pops++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
            if (exp_rdy) grants.push_back(cyc + rl);
            if (sending) begin
                sb.push_back(d);
                next_data = next_data + 32'd1;
            end
            check("proto_err", {31'b0, pe}, {31'b0, model_err});
            if (badnow) model_err = 1'b1;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            sb.delete();
            grants.delete();
            model_err = 1'b0;
        end
        while (grants.size() != 0 && grants[0] < cyc) void'(grants.pop_front());
    endtask

    initial begin
        int          p0;
        logic [31:0] n0;
        reset0 = 1'b1; in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b0;
        reset1 = 1'b1; in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;
        @(posedge clk);
        #1;

        // ---------------- instance 0, READY_LATENCY = 1 ----------------
        cur = 0; rl = 1;
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);

        // 8 beats at full rate
        next_data = '0; pops = 0; first_pop = -1;
        for (int i = 0; i < 14; i++) step(0, next_data < 8, 0, 1);
        check("s1_pops", pops, 32'd8);
        check("s1_rate", last_pop - first_pop, 32'd7);

        // sink stalled with continuous stream: exactly 4 beats stored
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0);
        p0 = pops;
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
        check("s2_drain", pops - p0, 32'd4);

        // short stall then streaming: simultaneous write/pop, pointer wrap
        p0 = pops; n0 = next_data;
        for (int i = 0; i < 2; i++) step(0, 1, 0, 0);
        for (int i = 0; i < 14; i++) step(0, 1, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        check("s3_all_out", pops - p0, next_data - n0);

        // ungranted beat: dropped, proto_err sticky
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        // reset with 3 stored beats and one grant outstanding
        check("s5_stored", sb.size(), 32'd3);
        check("s5_outstanding", grants.size(), 32'd1);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 1);
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(1, 0, 0, 0);

        // ---------------- instance 1, READY_LATENCY = 3 ----------------
        cur = 1; rl = 3;
        sb.delete(); grants.delete(); model_err = 1'b0;
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);

        next_data = '0; pops = 0;
        for (int i = 0; i < 40; i++) step(0, next_data < 8, 0, 1);
        check("r3_s1_pops", pops, 32'd8);

        p0 = pops; n0 = next_data;
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
        check("r3_s2_all_out", pops - p0, next_data - n0);

        p0 = pops; n0 = next_data;
        for (int i = 0; i < 300; i++)
            step(0, $urandom_range(0, 3) != 0, 0, $urandom_range(0, 2) != 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 1);
        check("r3_rand_all_out", pops - p0, next_data - n0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
